// File: rtl/gen_bus_arbiter.sv
// Two-master arbiter onto a single shared RAM port: round-robin or fixed priority,
// non-preemptive, with per-master completion counters.
module gen_bus_arbiter #(
    parameter string       ARB_MODE = "RR",
    parameter int unsigned CNT_W    = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    // requester 0 (core)
    input  logic [31:0]      m0_addr,
    input  logic             m0_ren,
    input  logic             m0_wen,
    input  logic [31:0]      m0_wdata,
    input  logic [3:0]       m0_byte_en,
    output logic [31:0]      m0_rdata,
    output logic             m0_busy,
    // requester 1 (debug / dump master)
    input  logic [31:0]      m1_addr,
    input  logic             m1_ren,
    input  logic             m1_wen,
    input  logic [31:0]      m1_wdata,
    input  logic [3:0]       m1_byte_en,
    output logic [31:0]      m1_rdata,
    output logic             m1_busy,
    // shared RAM port
    output logic [31:0]      s_addr,
    output logic             s_ren,
    output logic             s_wen,
    output logic [31:0]      s_wdata,
    output logic [3:0]       s_byte_en,
    input  logic [31:0]      s_rdata,
    input  logic             s_busy,
    // status
    output logic [1:0]       owner,
    output logic [CNT_W-1:0] m0_count,
    output logic [CNT_W-1:0] m1_count
);

    localparam bit FIXED_PRIO = (ARB_MODE == "FIXED");

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GRANT0 = 2'b01,
        GRANT1 = 2'b10
    } state_t;

    state_t           state_q;
    logic             last_grant_q;  // 0: M0 completed last, 1: M1 completed last
    logic [CNT_W-1:0] cnt0_q;
    logic [CNT_W-1:0] cnt1_q;

    logic req0;
    logic req1;

    assign req0 = m0_ren | m0_wen;
    assign req1 = m1_ren | m1_wen;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req0 && req1) begin
                        state_q <= (FIXED_PRIO || last_grant_q) ? GRANT0 : GRANT1;
                    end else if (req0) begin
                        state_q <= GRANT0;
                    end else if (req1) begin
                        state_q <= GRANT1;
                    end
                end
                GRANT0: begin
                    if (req0) begin
                        if (!s_busy) begin
                            cnt0_q       <= cnt0_q + CNT_W'(1);
                            last_grant_q <= 1'b0;
                            // Fixed priority keeps M0 parked while it keeps asking
                            if (req1 && !FIXED_PRIO) begin
                                state_q <= GRANT1;
                            end
                        end
                    end else begin
                        state_q <= req1 ? GRANT1 : IDLE;
                    end
                end
                GRANT1: begin
                    if (req1) begin
                        if (!s_busy) begin
                            cnt1_q       <= cnt1_q + CNT_W'(1);
                            last_grant_q <= 1'b1;
                            // Either mode hands back to a waiting M0
                            if (req0) begin
                                state_q <= GRANT0;
                            end
                        end
                    end else begin
                        state_q <= req0 ? GRANT0 : IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Slave mux is driven from the registered owner only
    always_comb begin
        s_addr    = '0;
        s_ren     = 1'b0;
        s_wen     = 1'b0;
        s_wdata   = '0;
        s_byte_en = '0;
        m0_busy   = 1'b1;
        m1_busy   = 1'b1;
        case (state_q)
            GRANT0: begin
                s_addr    = m0_addr;
                s_ren     = m0_ren;
                s_wen     = m0_wen;
                s_wdata   = m0_wdata;
                s_byte_en = m0_byte_en;
                m0_busy   = s_busy;
            end
            GRANT1: begin
                s_addr    = m1_addr;
                s_ren     = m1_ren;
                s_wen     = m1_wen;
                s_wdata   = m1_wdata;
                s_byte_en = m1_byte_en;
                m1_busy   = s_busy;
            end
            default: ;
        endcase
    end

    assign m0_rdata = s_rdata;
    assign m1_rdata = s_rdata;
    assign owner    = state_q;
    assign m0_count = cnt0_q;
    assign m1_count = cnt1_q;

endmodule

// File: tb/tb_gen_bus_arbiter.sv
// Bench for gen_bus_arbiter: three configurations (RR, FIXED, RR with 4-bit counters) share
// one stimulus stream and are checked against a rule-level model every cycle.
module tb_gen_bus_arbiter;

    localparam int NI = 3;  // 0: RR/32, 1: FIXED/32, 2: RR/4

    logic        CLK = 1'b0;
    logic        nRST;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, s_rdata;
    logic        m0_ren, m0_wen, m1_ren, m1_wen, s_busy;
    logic [3:0]  m0_byte_en, m1_byte_en;

    wire [NI-1:0][31:0] o_s_addr, o_s_wdata, o_m0_rdata, o_m1_rdata, o_c0, o_c1;
    wire [NI-1:0]       o_s_ren, o_s_wen, o_m0_busy, o_m1_busy;
    wire [NI-1:0][3:0]  o_s_be;
    wire [NI-1:0][1:0]  o_owner;

    assign o_c0[2][31:4] = '0;
    assign o_c1[2][31:4] = '0;

    always #5 CLK = ~CLK;

    gen_bus_arbiter #(.ARB_MODE("RR"), .CNT_W(32)) u_rr (
        .CLK(CLK), .nRST(nRST),
        .m0_addr(m0_addr), .m0_ren(m0_ren), .m0_wen(m0_wen), .m0_wdata(m0_wdata),
        .m0_byte_en(m0_byte_en), .m0_rdata(o_m0_rdata[0]), .m0_busy(o_m0_busy[0]),
        .m1_addr(m1_addr), .m1_ren(m1_ren), .m1_wen(m1_wen), .m1_wdata(m1_wdata),
        .m1_byte_en(m1_byte_en), .m1_rdata(o_m1_rdata[0]), .m1_busy(o_m1_busy[0]),
        .s_addr(o_s_addr[0]), .s_ren(o_s_ren[0]), .s_wen(o_s_wen[0]), .s_wdata(o_s_wdata[0]),
        .s_byte_en(o_s_be[0]), .s_rdata(s_rdata), .s_busy(s_busy),
        .owner(o_owner[0]), .m0_count(o_c0[0]), .m1_count(o_c1[0])
    );

    gen_bus_arbiter #(.ARB_MODE("FIXED"), .CNT_W(32)) u_fx (
        .CLK(CLK), .nRST(nRST),
        .m0_addr(m0_addr), .m0_ren(m0_ren), .m0_wen(m0_wen), .m0_wdata(m0_wdata),
        .m0_byte_en(m0_byte_en), .m0_rdata(o_m0_rdata[1]), .m0_busy(o_m0_busy[1]),
        .m1_addr(m1_addr), .m1_ren(m1_ren), .m1_wen(m1_wen), .m1_wdata(m1_wdata),
        .m1_byte_en(m1_byte_en), .m1_rdata(o_m1_rdata[1]), .m1_busy(o_m1_busy[1]),
        .s_addr(o_s_addr[1]), .s_ren(o_s_ren[1]), .s_wen(o_s_wen[1]), .s_wdata(o_s_wdata[1]),
        .s_byte_en(o_s_be[1]), .s_rdata(s_rdata), .s_busy(s_busy),
        .owner(o_owner[1]), .m0_count(o_c0[1]), .m1_count(o_c1[1])
    );

    gen_bus_arbiter #(.ARB_MODE("RR"), .CNT_W(4)) u_w4 (
        .CLK(CLK), .nRST(nRST),
        .m0_addr(m0_addr), .m0_ren(m0_ren), .m0_wen(m0_wen), .m0_wdata(m0_wdata),
        .m0_byte_en(m0_byte_en), .m0_rdata(o_m0_rdata[2]), .m0_busy(o_m0_busy[2]),
        .m1_addr(m1_addr), .m1_ren(m1_ren), .m1_wen(m1_wen), .m1_wdata(m1_wdata),
        .m1_byte_en(m1_byte_en), .m1_rdata(o_m1_rdata[2]), .m1_busy(o_m1_busy[2]),
        .s_addr(o_s_addr[2]), .s_ren(o_s_ren[2]), .s_wen(o_s_wen[2]), .s_wdata(o_s_wdata[2]),
        .s_byte_en(o_s_be[2]), .s_rdata(s_rdata), .s_busy(s_busy),
        .owner(o_owner[2]), .m0_count(o_c0[2][3:0]), .m1_count(o_c1[2][3:0])
    );

    int n_checks = 0;
    int n_err    = 0;
    int cyc_n    = 0;

    // Reference model: who holds the port (0 none, 1 = M0, 2 = M1), who completed last,
    // and completion counts kept modulo 2^CNT_W.
    int unsigned     md_owner [NI];
    int unsigned     md_last  [NI];
    longint unsigned md_cnt   [NI][2];

    function automatic longint unsigned cnt_mod(input int k);
        return (k == 2) ? 64'd16 : 64'h1_0000_0000;
    endfunction

    function automatic string iname(input int k);
        return (k == 0) ? "rr" : ((k == 1) ? "fx" : "w4");
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got 0x%0h, want 0x%0h", name, cyc_n, act, exp);
        end
    endtask

    task automatic model_step();
        bit          req [2];
        bit          fixed;
        int unsigned n, o;
        req[0] = m0_ren | m0_wen;
        req[1] = m1_ren | m1_wen;
        for (int k = 0; k < NI; k++) begin
            fixed = (k == 1);
            if (!nRST) begin
                md_owner[k]  = 0;
                md_last[k]   = 1;
                md_cnt[k][0] = 0;
                md_cnt[k][1] = 0;
            end else if (md_owner[k] == 0) begin
                if (req[0] && req[1]) md_owner[k] = fixed ? 1 : 2 - md_last[k];
                else if (req[0])      md_owner[k] = 1;
                else if (req[1])      md_owner[k] = 2;
            end else begin
                n = md_owner[k] - 1;
                o = 1 - n;
                if (req[n] && !s_busy) begin
                    md_cnt[k][n] = (md_cnt[k][n] + 1) % cnt_mod(k);
                    md_last[k]   = n;
                    if (req[o] && (!fixed || o == 0)) md_owner[k] = o + 1;
                end else if (!req[n]) begin
                    md_owner[k] = req[o] ? o + 1 : 0;
                end
            end
        end
    endtask

    task automatic model_check();
        logic [69:0] exp_s;
        logic [1:0]  exp_b;
        for (int k = 0; k < NI; k++) begin
            exp_s = '0;
            exp_b = 2'b11;
            if (md_owner[k] == 1) begin
                exp_s    = {m0_addr, m0_ren, m0_wen, m0_wdata, m0_byte_en};
                exp_b[0] = s_busy;
            end else if (md_owner[k] == 2) begin
                exp_s    = {m1_addr, m1_ren, m1_wen, m1_wdata, m1_byte_en};
                exp_b[1] = s_busy;
            end
            chk({iname(k), " owner"}, 128'(o_owner[k]), 128'(md_owner[k]));
            chk({iname(k), " s_port"},
                128'({o_s_addr[k], o_s_ren[k], o_s_wen[k], o_s_wdata[k], o_s_be[k]}),
                128'(exp_s));
            chk({iname(k), " busy{m1,m0}"}, 128'({o_m1_busy[k], o_m0_busy[k]}), 128'(exp_b));
            chk({iname(k), " rdata{m1,m0}"}, 128'({o_m1_rdata[k], o_m0_rdata[k]}),
                128'({s_rdata, s_rdata}));
            chk({iname(k), " m0_count"}, 128'(o_c0[k]), 128'(md_cnt[k][0]));
            chk({iname(k), " m1_count"}, 128'(o_c1[k]), 128'(md_cnt[k][1]));
        end
    endtask

    task automatic mid();
        @(negedge CLK);
        model_check();
    endtask

    task automatic fin();
        @(posedge CLK);
        model_step();
        cyc_n++;
        #1;
    endtask

    task automatic cyc();
        mid();
        fin();
    endtask

    task automatic set_m(input int idx, input bit ren, input bit wen, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
        if (idx == 0) begin
            m0_ren = ren; m0_wen = wen; m0_addr = addr; m0_wdata = wdata; m0_byte_en = be;
        end else begin
            m1_ren = ren; m1_wen = wen; m1_addr = addr; m1_wdata = wdata; m1_byte_en = be;
        end
    endtask

    task automatic clr_m(input int idx);
        set_m(idx, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic rand_m(input int idx);
        int unsigned r;
        logic [31:0] a, d, b;
        r = $urandom_range(0, 3);
        a = $urandom;
        d = $urandom;
        b = $urandom;
        set_m(idx, r[0], r[1], a, d, b[3:0]);
    endtask

    task automatic do_reset();
        nRST    = 1'b0;
        clr_m(0);
        clr_m(1);
        s_busy  = 1'b1;
        s_rdata = '0;
        fin();
        mid();
        fin();
        nRST = 1'b1;
    endtask

    typedef struct packed {
        bit         r0;
        bit         r1;
        bit         busy;
        logic [1:0] own_rr;
        logic [1:0] own_fx;
        logic [3:0] c0_rr, c1_rr, c0_fx, c1_fx;
    } vec_t;

    vec_t tbl [5];

    initial begin
        // Simultaneous M0 write / M1 read right after reset
        tbl[0] = '{r0: 1, r1: 1, busy: 1, own_rr: 2'b00, own_fx: 2'b00,
                   c0_rr: 0, c1_rr: 0, c0_fx: 0, c1_fx: 0};
        tbl[1] = '{r0: 1, r1: 1, busy: 0, own_rr: 2'b01, own_fx: 2'b01,
                   c0_rr: 0, c1_rr: 0, c0_fx: 0, c1_fx: 0};
        tbl[2] = '{r0: 0, r1: 1, busy: 0, own_rr: 2'b10, own_fx: 2'b01,
                   c0_rr: 1, c1_rr: 0, c0_fx: 1, c1_fx: 0};
        tbl[3] = '{r0: 0, r1: 0, busy: 0, own_rr: 2'b10, own_fx: 2'b10,
                   c0_rr: 1, c1_rr: 1, c0_fx: 1, c1_fx: 0};
        tbl[4] = '{r0: 0, r1: 0, busy: 0, own_rr: 2'b00, own_fx: 2'b00,
                   c0_rr: 1, c1_rr: 1, c0_fx: 1, c1_fx: 0};

        // Reset state
        do_reset();
        mid();
        for (int k = 0; k < NI; k++) begin
            chk({"reset owner ", iname(k)}, 128'(o_owner[k]), 128'(2'b00));
            chk({"reset busy ", iname(k)}, 128'({o_m1_busy[k], o_m0_busy[k]}), 128'(2'b11));
            chk({"reset strobes ", iname(k)}, 128'({o_s_ren[k], o_s_wen[k]}), 128'(2'b00));
        end
        fin();

        // Single M0 read of 0x100, RAM busy for two cycles
        set_m(0, 1'b1, 1'b0, 32'h100, 32'h0, 4'hf);
        s_busy = 1'b1;
        mid(); chk("r030 owner idle", 128'(o_owner[0]), 128'(2'b00)); fin();
        mid();
        chk("r030 owner grant", 128'(o_owner[0]), 128'(2'b01));
        chk("r030 s_addr", 128'(o_s_addr[0]), 128'(32'h100));
        chk("r030 m0_busy wait", 128'(o_m0_busy[0]), 128'(1'b1));
        fin();
        mid(); chk("r030 m1_busy", 128'(o_m1_busy[0]), 128'(1'b1)); fin();
        s_busy  = 1'b0;
        s_rdata = 32'hCAFE_0100;
        mid();
        chk("r030 m0_busy done", 128'(o_m0_busy[0]), 128'(1'b0));
        chk("r030 m0_rdata", 128'(o_m0_rdata[0]), 128'(32'hCAFE_0100));
        chk("r030 m1_busy done", 128'(o_m1_busy[0]), 128'(1'b1));
        fin();
        clr_m(0);
        s_busy = 1'b1;
        mid(); chk("r030 m0_count", 128'(o_c0[0]), 128'(32'd1)); fin();
        mid(); chk("r030 back idle", 128'(o_owner[0]), 128'(2'b00)); fin();

        // Tie after reset: table of cycles
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_m(0, 1'b0, tbl[i].r0, 32'h0, 32'h1234_5678, 4'hf);
            set_m(1, tbl[i].r1, 1'b0, 32'h104, 32'h0, 4'hf);
            s_busy = tbl[i].busy;
            mid();
            for (int k = 0; k < NI; k += 2) begin
                chk($sformatf("tbl%0d owner %s", i, iname(k)), 128'(o_owner[k]),
                    128'(tbl[i].own_rr));
                chk($sformatf("tbl%0d c0 %s", i, iname(k)), 128'(o_c0[k]), 128'(tbl[i].c0_rr));
                chk($sformatf("tbl%0d c1 %s", i, iname(k)), 128'(o_c1[k]), 128'(tbl[i].c1_rr));
            end
            chk($sformatf("tbl%0d owner fx", i), 128'(o_owner[1]), 128'(tbl[i].own_fx));
            chk($sformatf("tbl%0d c0 fx", i), 128'(o_c0[1]), 128'(tbl[i].c0_fx));
            chk($sformatf("tbl%0d c1 fx", i), 128'(o_c1[1]), 128'(tbl[i].c1_fx));
            fin();
        end

        // FIXED: M0 keeps requesting, M1 starves while M0 stays parked
        do_reset();
        set_m(0, 1'b1, 1'b0, 32'h200, 32'h0, 4'hf);
        set_m(1, 1'b1, 1'b0, 32'h300, 32'h0, 4'hf);
        s_busy = 1'b0;
        cyc();
        for (int i = 0; i < 10; i++) begin
            mid();
            chk("fixed parked owner", 128'(o_owner[1]), 128'(2'b01));
            chk("fixed m1_busy", 128'(o_m1_busy[1]), 128'(1'b1));
            fin();
        end
        mid();
        chk("fixed m0_count", 128'(o_c0[1]), 128'(32'd10));
        chk("fixed m1_count", 128'(o_c1[1]), 128'(32'd0));
        fin();

        // Counter wrap on the 4-bit instance: 17 M0 completions
        do_reset();
        set_m(0, 1'b1, 1'b0, 32'h240, 32'h0, 4'hf);
        s_busy = 1'b0;
        cyc();
        for (int i = 0; i < 17; i++) cyc();
        mid();
        chk("wrap w4 m0_count", 128'(o_c0[2]), 128'(32'd1));
        chk("wrap rr m0_count", 128'(o_c0[0]), 128'(32'd17));
        fin();

        // No preemption: M1 holds a 5-cycle busy access while M0 asks
        do_reset();
        set_m(1, 1'b1, 1'b0, 32'h400, 32'h0, 4'hf);
        s_busy = 1'b1;
        cyc();
        for (int i = 0; i < 5; i++) begin
            if (i == 1) set_m(0, 1'b0, 1'b1, 32'h500, 32'h5555_AAAA, 4'h3);
            mid();
            chk("nopre owner rr", 128'(o_owner[0]), 128'(2'b10));
            chk("nopre owner fx", 128'(o_owner[1]), 128'(2'b10));
            chk("nopre s_addr", 128'(o_s_addr[0]), 128'(32'h400));
            fin();
        end
        s_busy = 1'b0;
        mid(); chk("nopre m1 done", 128'(o_m1_busy[0]), 128'(1'b0)); fin();
        clr_m(1);
        s_busy = 1'b1;
        mid();
        chk("nopre handoff rr", 128'(o_owner[0]), 128'(2'b01));
        chk("nopre handoff fx", 128'(o_owner[1]), 128'(2'b01));
        chk("nopre s_addr m0", 128'(o_s_addr[0]), 128'(32'h500));
        fin();

        // Reset in the middle of an M1 write
        do_reset();
        set_m(0, 1'b1, 1'b0, 32'h600, 32'h0, 4'hf);
        set_m(1, 1'b0, 1'b1, 32'h700, 32'hAA55_AA55, 4'hf);
        s_busy = 1'b0;
        cyc();
        cyc();
        clr_m(0);
        s_busy = 1'b1;
        cyc();
        mid();
        chk("rst pre owner", 128'(o_owner[0]), 128'(2'b10));
        chk("rst pre s_wen", 128'(o_s_wen[0]), 128'(1'b1));
        chk("rst pre m0_count", 128'(o_c0[0]), 128'(32'd1));
        fin();
        nRST = 1'b0;
        cyc();
        nRST = 1'b1;
        mid();
        for (int k = 0; k < NI; k++) begin
            chk({"rst owner ", iname(k)}, 128'(o_owner[k]), 128'(2'b00));
            chk({"rst s_wen ", iname(k)}, 128'(o_s_wen[k]), 128'(1'b0));
            chk({"rst counts ", iname(k)}, 128'({o_c0[k], o_c1[k]}), 128'(64'd0));
        end
        fin();
        mid(); chk("rst regrant", 128'(o_owner[0]), 128'(2'b10)); fin();

        // Randomized traffic, every cycle checked against the model
        for (int i = 0; i < 400; i++) begin
            nRST = ($urandom_range(0, 39) != 0);
            if ($urandom_range(0, 3) == 0) rand_m(0);
            if ($urandom_range(0, 3) == 0) rand_m(1);
            s_busy  = ($urandom_range(0, 1) == 1);
            s_rdata = $urandom;
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
